// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: three 1-entry request buffers share one registered write port.
// Define REGFILE_WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority req0 > req1 > req2.
module regfile_wb_arbiter #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_req0_valid,
   output logic                    o_req0_ready,
   input  logic [ADDR_W-1:0]       i_req0_addr,
   input  logic [DATA_W-1:0]       i_req0_wdata,
   input  logic                    i_req1_valid,
   output logic                    o_req1_ready,
   input  logic [ADDR_W-1:0]       i_req1_addr,
   input  logic [DATA_W-1:0]       i_req1_wdata,
   input  logic                    i_req2_valid,
   output logic                    o_req2_ready,
   input  logic [ADDR_W-1:0]       i_req2_addr,
   input  logic [DATA_W-1:0]       i_req2_wdata,
   output logic                    o_wen,
   output logic [ADDR_W-1:0]       o_addr,
   output logic [DATA_W-1:0]       o_wdata,
   output logic [2**ADDR_W-1:0]    o_pending,
   output logic                    o_busy
);

   localparam int NREG = 2**ADDR_W;

   logic [2:0]        buf_vld;
   logic [ADDR_W-1:0] buf_addr [3];
   logic [DATA_W-1:0] buf_data [3];
   logic [2:0]        req_valid;
   logic [2:0]        ready;
   logic [2:0]        accept;
   logic [2:0]        grant;
   logic [ADDR_W-1:0] req_addr [3];
   logic [DATA_W-1:0] req_data [3];
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_data;
   logic [NREG-1:0]   pending;

   assign req_valid   = {i_req2_valid, i_req1_valid, i_req0_valid};
   assign req_addr[0] = i_req0_addr;
   assign req_addr[1] = i_req1_addr;
   assign req_addr[2] = i_req2_addr;
   assign req_data[0] = i_req0_wdata;
   assign req_data[1] = i_req1_wdata;
   assign req_data[2] = i_req2_wdata;

   // A buffer being drained this cycle can take a new entry on the same edge.
   assign ready        = ~buf_vld | grant;
   assign accept       = req_valid & ready;
   assign o_req0_ready = ready[0];
   assign o_req1_ready = ready[1];
   assign o_req2_ready = ready[2];

`ifdef REGFILE_WB_ARB_RR_EN
   logic [1:0] rr_ptr;

   // rr_ptr holds the last granted requester; search starts one past it.
   always_comb begin
      grant = 3'b000;
      case (rr_ptr)
         2'd0: begin
            if (buf_vld[1])      grant = 3'b010;
            else if (buf_vld[2]) grant = 3'b100;
            else if (buf_vld[0]) grant = 3'b001;
         end
         2'd1: begin
            if (buf_vld[2])      grant = 3'b100;
            else if (buf_vld[0]) grant = 3'b001;
            else if (buf_vld[1]) grant = 3'b010;
         end
         default: begin
            if (buf_vld[0])      grant = 3'b001;
            else if (buf_vld[1]) grant = 3'b010;
            else if (buf_vld[2]) grant = 3'b100;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 2'd2;
      end else if (|grant) begin
         rr_ptr <= grant[0] ? 2'd0 : (grant[1] ? 2'd1 : 2'd2);
      end
   end
`else
   always_comb begin
      grant = 3'b000;
      if (buf_vld[0])      grant = 3'b001;
      else if (buf_vld[1]) grant = 3'b010;
      else if (buf_vld[2]) grant = 3'b100;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_vld <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            buf_addr[i] <= '0;
            buf_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (accept[i]) begin
               buf_vld[i]  <= 1'b1;
               buf_addr[i] <= req_addr[i];
               buf_data[i] <= req_data[i];
            end else if (grant[i]) begin
               buf_vld[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      grant_addr = '0;
      grant_data = '0;
      for (int i = 0; i < 3; i++) begin
         if (grant[i]) begin
            grant_addr = buf_addr[i];
            grant_data = buf_data[i];
         end
      end
   end

   // Writes to x0 are drained silently; the write port keeps its last address/data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_wen   <= 1'b0;
         o_addr  <= '0;
         o_wdata <= '0;
      end else begin
         o_wen <= (|grant) && (grant_addr != '0);
         if ((|grant) && (grant_addr != '0)) begin
            o_addr  <= grant_addr;
            o_wdata <= grant_data;
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < 3; i++) begin
         if (buf_vld[i] && (buf_addr[i] != '0)) pending[buf_addr[i]] = 1'b1;
      end
      if (o_wen) pending[o_addr] = 1'b1;
      pending[0] = 1'b0;
   end

   assign o_pending = pending;
   assign o_busy    = (|buf_vld) | o_wen;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expected writes go through a scoreboard queue.
// Honours REGFILE_WB_ARB_RR_EN to select the expected grant order.
module tb_regfile_wb_arbiter;

   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int NREG   = 2**ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_req0_valid, i_req1_valid, i_req2_valid;
   logic              o_req0_ready, o_req1_ready, o_req2_ready;
   logic [ADDR_W-1:0] i_req0_addr, i_req1_addr, i_req2_addr;
   logic [DATA_W-1:0] i_req0_wdata, i_req1_wdata, i_req2_wdata;
   logic              o_wen;
   logic [ADDR_W-1:0] o_addr;
   logic [DATA_W-1:0] o_wdata;
   logic [NREG-1:0]   o_pending;
   logic              o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [ADDR_W-1:0] exp_addr_q [$];
   logic [DATA_W-1:0] exp_data_q [$];
   logic [ADDR_W-1:0] s_addr [3][16];
   logic [DATA_W-1:0] s_data [3][16];
   int                s_cnt [3];
   int                s_idx [3];
   logic [2:0]        hs_last;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_req0_valid (i_req0_valid),
      .o_req0_ready (o_req0_ready),
      .i_req0_addr  (i_req0_addr),
      .i_req0_wdata (i_req0_wdata),
      .i_req1_valid (i_req1_valid),
      .o_req1_ready (o_req1_ready),
      .i_req1_addr  (i_req1_addr),
      .i_req1_wdata (i_req1_wdata),
      .i_req2_valid (i_req2_valid),
      .o_req2_ready (o_req2_ready),
      .i_req2_addr  (i_req2_addr),
      .i_req2_wdata (i_req2_wdata),
      .o_wen        (o_wen),
      .o_addr       (o_addr),
      .o_wdata      (o_wdata),
      .o_pending    (o_pending),
      .o_busy       (o_busy)
   );

   task automatic check_output(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic add_item(input int n, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      s_addr[n][s_cnt[n]] = a;
      s_data[n][s_cnt[n]] = d;
      s_cnt[n]++;
   endtask

   task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(d);
   endtask

   task automatic clear_sources;
      for (int n = 0; n < 3; n++) begin
         s_cnt[n] = 0;
         s_idx[n] = 0;
      end
   endtask

   task automatic drive_inputs;
      int k0, k1, k2;
      k0 = (s_idx[0] < s_cnt[0]) ? s_idx[0] : 0;
      k1 = (s_idx[1] < s_cnt[1]) ? s_idx[1] : 0;
      k2 = (s_idx[2] < s_cnt[2]) ? s_idx[2] : 0;
      i_req0_valid = (s_idx[0] < s_cnt[0]);
      i_req0_addr  = s_addr[0][k0];
      i_req0_wdata = s_data[0][k0];
      i_req1_valid = (s_idx[1] < s_cnt[1]);
      i_req1_addr  = s_addr[1][k1];
      i_req1_wdata = s_data[1][k1];
      i_req2_valid = (s_idx[2] < s_cnt[2]);
      i_req2_addr  = s_addr[2][k2];
      i_req2_wdata = s_data[2][k2];
   endtask

   // One clock: present requests, record handshakes, then score any write on the port.
   task automatic apply_stimulus;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      drive_inputs();
      @(negedge clk);
      hs_last = {i_req2_valid & o_req2_ready, i_req1_valid & o_req1_ready, i_req0_valid & o_req0_ready};
      @(posedge clk);
      #1;
      for (int n = 0; n < 3; n++) if (hs_last[n]) s_idx[n]++;
      if (o_wen) begin
         if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_write: observed addr=%0d data=%0h expected no write", o_addr, o_wdata);
         end else begin
            a = exp_addr_q.pop_front();
            d = exp_data_q.pop_front();
            check_output("wb_addr", o_addr, a);
            check_output("wb_data", o_wdata, d);
         end
      end
      drive_inputs();
   endtask

   task automatic drain(input int max_cycles);
      int c;
      c = 0;
      while ((exp_addr_q.size() != 0) && (c < max_cycles)) begin
         apply_stimulus();
         c++;
      end
      check_output("drain_queue_empty", exp_addr_q.size(), 0);
      repeat (2) apply_stimulus();
      clear_sources();
   endtask

   initial begin
      for (int n = 0; n < 3; n++) begin
         for (int k = 0; k < 16; k++) begin
            s_addr[n][k] = '0;
            s_data[n][k] = '0;
         end
      end
      clear_sources();
      drive_inputs();

      #12;
      check_output("rst_wen", o_wen, 0);
      check_output("rst_addr", o_addr, 0);
      check_output("rst_wdata", o_wdata, 0);
      check_output("rst_pending", o_pending, 0);
      check_output("rst_busy", o_busy, 0);
      #8 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Simultaneous requests from all three: same order for both arbitration modes.
      add_item(0, 5'd1, 64'h1111);
      add_item(1, 5'd2, 64'h2222);
      add_item(2, 5'd3, 64'h3333);
      expect_write(5'd1, 64'h1111);
      expect_write(5'd2, 64'h2222);
      expect_write(5'd3, 64'h3333);
      apply_stimulus();
      check_output("sim_hs_all", hs_last, 3'b111);
      check_output("sim_pending_c1", o_pending, 32'h0000_000E);
      repeat (3) apply_stimulus();
      check_output("sim_busy_c4", o_busy, 1);
      apply_stimulus();
      check_output("sim_busy_c5", o_busy, 0);
      check_output("sim_queue_empty", exp_addr_q.size(), 0);
      clear_sources();

      // req0 and req2 competing continuously.
      for (int k = 0; k < 6; k++) add_item(0, 5'(10 + k), 64'hA0 + 64'(k));
      for (int k = 0; k < 3; k++) add_item(2, 5'(20 + k), 64'hC0 + 64'(k));
`ifdef REGFILE_WB_ARB_RR_EN
      for (int k = 0; k < 3; k++) begin
         expect_write(5'(10 + k), 64'hA0 + 64'(k));
         expect_write(5'(20 + k), 64'hC0 + 64'(k));
      end
      for (int k = 3; k < 6; k++) expect_write(5'(10 + k), 64'hA0 + 64'(k));
      apply_stimulus();
      apply_stimulus();
      check_output("rr_req2_ready_when_granted", o_req2_ready, 1);
`else
      for (int k = 0; k < 6; k++) expect_write(5'(10 + k), 64'hA0 + 64'(k));
      for (int k = 0; k < 3; k++) expect_write(5'(20 + k), 64'hC0 + 64'(k));
      for (int k = 1; k <= 5; k++) begin
         apply_stimulus();
         check_output("fixed_req2_starved_ready", o_req2_ready, 0);
      end
`endif
      drain(40);

      // Single write latency and pending tracking.
      add_item(0, 5'd5, 64'h1234);
      expect_write(5'd5, 64'h1234);
      apply_stimulus();
      check_output("single_pending_c1", o_pending, 32'h0000_0020);
      check_output("single_wen_c1", o_wen, 0);
      apply_stimulus();
      check_output("single_wen_c2", o_wen, 1);
      check_output("single_pending_c2", o_pending, 32'h0000_0020);
      apply_stimulus();
      check_output("single_pending_c3", o_pending, 0);
      check_output("single_busy_c3", o_busy, 0);
      clear_sources();

      // Back-to-back from the LSU.
      for (int k = 0; k < 4; k++) begin
         add_item(1, 5'(6 + k), 64'hB000 + 64'(k));
         expect_write(5'(6 + k), 64'hB000 + 64'(k));
      end
      for (int k = 1; k <= 5; k++) begin
         apply_stimulus();
         if (k <= 4) check_output("b2b_handshake", hs_last[1], 1);
         if (k >= 2) check_output("b2b_wen", o_wen, 1);
      end
      drain(10);

      // Write to x0: drained without touching the register file.
      add_item(2, 5'd0, 64'hFFFF);
      apply_stimulus();
      check_output("x0_accepted", hs_last[2], 1);
      check_output("x0_ready_again", o_req2_ready, 1);
      check_output("x0_pending_c1", o_pending, 0);
      check_output("x0_busy_c1", o_busy, 1);
      apply_stimulus();
      check_output("x0_wen_c2", o_wen, 0);
      check_output("x0_pending_c2", o_pending, 0);
      clear_sources();
      apply_stimulus();

      // Asynchronous reset with all buffers full.
      add_item(0, 5'd11, 64'hD011);
      add_item(1, 5'd12, 64'hD012);
      add_item(2, 5'd13, 64'hD013);
      apply_stimulus();
      check_output("prereset_pending", o_pending, 32'h0000_3800);
      clear_sources();
      drive_inputs();
      #2 rst_n = 1'b0;
      #1;
      check_output("midrst_wen", o_wen, 0);
      check_output("midrst_pending", o_pending, 0);
      check_output("midrst_busy", o_busy, 0);
      @(posedge clk);
      #1;
      check_output("midrst_wen_held", o_wen, 0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         apply_stimulus();
         check_output("postrst_no_write", o_wen, 0);
      end
      check_output("postrst_busy", o_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (wen/addr/wdata) among three writeback requesters: req0 = EXU (ALU), req1 = LSU (loads), req2 = MDU (mul/div).
- Each requester has a 1-entry holding buffer. One buffered write is granted per cycle and driven to the register file through a registered output stage.
- Exports a per-register pending mask so decode can stall RAW hazards on writes not yet committed.

Parameters:
- DATA_W, 64, register data width
- ADDR_W, 5, register index width; register count is 2**ADDR_W (32)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- i_req0_valid  in  1  EXU write request
- o_req0_ready  out  1  EXU request accepted when valid & ready
- i_req0_addr  in  ADDR_W  EXU destination register
- i_req0_wdata  in  DATA_W  EXU write data
- i_req1_valid / o_req1_ready / i_req1_addr / i_req1_wdata  same as req0, LSU
- i_req2_valid / o_req2_ready / i_req2_addr / i_req2_wdata  same as req0, MDU
- o_wen  out  1  register-file write enable
- o_addr  out  ADDR_W  register-file write address
- o_wdata  out  DATA_W  register-file write data
- o_pending  out  2**ADDR_W  bit r = write to register r is buffered or in output stage
- o_busy  out  1  any buffer occupied or o_wen high

Behaviour:
- Reset (async, rst_n=0): all buffer valid bits 0; o_wen=0, o_addr=0, o_wdata=0; o_pending=0; o_busy=0; RR pointer = 2, so req0 has first priority.
- Buffer n accepts on the clk edge where i_reqn_valid & o_reqn_ready. It stores addr and wdata.
- o_reqn_ready = ~buf_vld[n] | grant[n]. A full buffer being granted this cycle accepts a new entry on the same edge, giving 1 write/cycle/requester throughput.
- Arbitration is combinational over buffer valid bits only. At most one grant per cycle. The granted buffer clears on the edge unless it is refilled on that same edge.
- Output stage is registered. On the edge after a grant: o_wen=1, o_addr/o_wdata = granted entry, held for exactly one cycle. With no grant: o_wen=0 and o_addr/o_wdata hold their last values.
- Latency: handshake in cycle 0, buffer valid in cycle 1, if granted in cycle 1 then o_wen is high in cycle 2. The register file commits at the end of cycle 2. Minimum 2 cycles.
- addr==0 entries are accepted and granted like any other, but o_wen stays 0 for them. They never set o_pending.
- o_pending: OR of decoded addr of each valid buffer (addr!=0), plus o_addr when o_wen=1. Bit 0 is always 0. Output is combinational from registered state.
- Constraint on requesters: at most one outstanding write per register across all three requesters. Decode enforces this using o_pending. The arbiter does not reorder same-address writes.
- Mid-operation reset discards buffered entries and the in-flight write. No register-file write occurs while rst_n=0.
- All three buffers full and none draining: all readies low. Requesters must hold valid and data stable until the handshake.

Optional Feature:
- Macro: REGFILE_WB_ARB_RR_EN.
- Defined: round-robin arbitration. Priority starts at (last_grant+1) mod 3. The pointer updates only on a grant.
- Undefined: fixed priority req0 > req1 > req2. The pointer logic is removed. req2 may starve under continuous req0/req1 traffic.

Test Plan:
- Single write: req0 valid, addr=5, wdata=0x1234 in cycle 0 -> o_pending[5]=1 in cycle 1; o_wen=1, o_addr=5, o_wdata=0x1234 in cycle 2; o_pending=0 in cycle 3.
- Simultaneous: req0/1/2 handshake in cycle 0 with addr 1/2/3 -> RR: o_wen cycles 2,3,4 with addr 1,2,3. Fixed priority gives the same order. o_busy drops in cycle 5.
- Starvation: req0 and req2 held valid every cycle with distinct addresses -> RR: grants alternate 0,2,0,2. Fixed: req2 never granted and o_req2_ready stays 0 once its buffer fills.
- Back-to-back: req1 valid 4 consecutive cycles, addr 6..9 -> o_req1_ready stays 1, o_wen high 4 consecutive cycles with addr 6,7,8,9.
- x0 write: req2 addr=0, wdata=0xFFFF -> accepted, o_wen stays 0, o_pending stays 0, o_req2_ready high again the next cycle.
- Reset mid-operation: fill all three buffers, assert rst_n=0 asynchronously -> immediately o_wen=0, o_pending=0, o_busy=0. After release, no stale write appears.
